// File: rtl/netlist_net_collector.sv
// netlist_net_collector
// Buffers an instance-major {instance, pin, net} record stream, then re-emits
// it net-major: ascending net id, arrival order within a net.
// Optional build macro NETCOL_DANGLING_DROP_EN: each net gets a count pass
// before its emit pass, and nets with fewer than two pins are suppressed.
module netlist_net_collector #(
   parameter int unsigned INST_W   = 8,
   parameter int unsigned PIN_W    = 3,
   parameter int unsigned NET_W    = 4,
   parameter int unsigned NUM_NETS = 16,
   parameter int unsigned MAX_RECS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PIN_W-1:0]  in_pin,
   input  logic [NET_W-1:0]  in_net,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PIN_W-1:0]  out_pin,
   output logic [NET_W-1:0]  out_net,
   output logic              out_first,
   output logic              done,
   output logic              err_overflow,
   output logic              err_range
);

   localparam int unsigned CNT_W = $clog2(MAX_RECS + 1);
   localparam int unsigned ADR_W = (MAX_RECS > 1) ? $clog2(MAX_RECS) : 1;
   localparam int unsigned REC_W = INST_W + PIN_W + NET_W;

   typedef enum logic [1:0] {S_LOAD, S_SCAN, S_DONE} state_t;

   state_t           r_state;
   logic [REC_W-1:0] r_mem [MAX_RECS];
   logic [CNT_W-1:0] r_cnt;
   logic [ADR_W-1:0] r_a;
   logic [NET_W-1:0] r_n;
   logic             r_prep;   // first SCAN cycle: initialise scan counters
   logic             r_end;    // scan exhausted, leave once the output drains
   logic             r_got;    // current net already emitted a pin
   logic             r_fresh;  // next accepted record starts a new load
`ifdef NETCOL_DANGLING_DROP_EN
   logic             r_emit_ph;
   logic [1:0]       r_pcnt;
   logic [1:0]       w_pc_next;
`endif

   logic             w_xfer, w_bad_net, w_full, w_store;
   logic [REC_W-1:0] w_rec;
   logic             w_match, w_a_last, w_n_last, w_stall;

   assign w_xfer    = in_valid && in_ready;
   assign w_bad_net = 32'(in_net) >= NUM_NETS;
   assign w_full    = (r_cnt == CNT_W'(MAX_RECS));
   assign w_store   = w_xfer && !w_bad_net && !w_full;
   assign w_rec     = r_mem[r_a];
   assign w_match   = (w_rec[NET_W-1:0] == r_n);
   assign w_a_last  = (CNT_W'(r_a) == r_cnt - CNT_W'(1));
   assign w_n_last  = (r_n == NET_W'(NUM_NETS - 1));
   // Scan progress freezes while a registered output awaits its handshake
   assign w_stall   = out_valid && !out_ready;

`ifdef NETCOL_DANGLING_DROP_EN
   // Saturating pin count for the net being counted (only "0, 1, >=2" matters)
   always_comb begin
      w_pc_next = r_pcnt;
      if (w_match && (r_pcnt != 2'd2)) w_pc_next = r_pcnt + 2'd1;
   end
`endif

   // Record buffer write, stored at the current count
   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_cnt[ADR_W-1:0]] <= {in_inst, in_pin, in_net};
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_LOAD;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_inst     <= '0;
         out_pin      <= '0;
         out_net      <= '0;
         out_first    <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         err_range    <= 1'b0;
         r_cnt        <= '0;
         r_a          <= '0;
         r_n          <= '0;
         r_prep       <= 1'b0;
         r_end        <= 1'b0;
         r_got        <= 1'b0;
         r_fresh      <= 1'b1;
`ifdef NETCOL_DANGLING_DROP_EN
         r_emit_ph    <= 1'b0;
         r_pcnt       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_LOAD: begin
               if (w_xfer) begin
                  if (r_fresh) begin
                     err_overflow <= 1'b0;
                     err_range    <= 1'b0;
                     r_fresh      <= 1'b0;
                  end
                  if (w_bad_net)   err_range    <= 1'b1;
                  else if (w_full) err_overflow <= 1'b1;
                  else             r_cnt        <= r_cnt + CNT_W'(1);
                  if (in_last) begin
                     r_state  <= S_SCAN;
                     in_ready <= 1'b0;
                     r_prep   <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (r_prep) begin
                  r_prep <= 1'b0;
                  r_end  <= (r_cnt == '0);
                  r_a    <= '0;
                  r_n    <= '0;
                  r_got  <= 1'b0;
`ifdef NETCOL_DANGLING_DROP_EN
                  r_emit_ph <= 1'b0;
                  r_pcnt    <= '0;
`endif
               end else if (!w_stall) begin
                  out_valid <= 1'b0;
                  out_first <= 1'b0;
                  if (r_end) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
`ifdef NETCOL_DANGLING_DROP_EN
                     if (!r_emit_ph) begin
                        // Count pass: emit pass follows only for nets with >= 2 pins
                        if (w_a_last) begin
                           r_a    <= '0;
                           r_pcnt <= '0;
                           if (w_pc_next == 2'd2) r_emit_ph <= 1'b1;
                           else begin
                              r_got <= 1'b0;
                              if (w_n_last) r_end <= 1'b1;
                              else          r_n   <= r_n + NET_W'(1);
                           end
                        end else begin
                           r_a    <= r_a + ADR_W'(1);
                           r_pcnt <= w_pc_next;
                        end
                     end else begin
                        if (w_match) begin
                           out_valid <= 1'b1;
                           out_inst  <= w_rec[REC_W-1 -: INST_W];
                           out_pin   <= w_rec[NET_W +: PIN_W];
                           out_net   <= w_rec[NET_W-1:0];
                           out_first <= !r_got;
                           r_got     <= 1'b1;
                        end
                        if (w_a_last) begin
                           r_a       <= '0;
                           r_emit_ph <= 1'b0;
                           r_got     <= 1'b0;
                           if (w_n_last) r_end <= 1'b1;
                           else          r_n   <= r_n + NET_W'(1);
                        end else begin
                           r_a <= r_a + ADR_W'(1);
                        end
                     end
`else
                     if (w_match) begin
                        out_valid <= 1'b1;
                        out_inst  <= w_rec[REC_W-1 -: INST_W];
                        out_pin   <= w_rec[NET_W +: PIN_W];
                        out_net   <= w_rec[NET_W-1:0];
                        out_first <= !r_got;
                        r_got     <= 1'b1;
                     end
                     if (w_a_last) begin
                        r_a   <= '0;
                        r_got <= 1'b0;
                        if (w_n_last) r_end <= 1'b1;
                        else          r_n   <= r_n + NET_W'(1);
                     end else begin
                        r_a <= r_a + ADR_W'(1);
                     end
`endif
                  end
               end
            end
            S_DONE: begin
               r_cnt    <= '0;
               in_ready <= 1'b1;
               r_fresh  <= 1'b1;
               r_state  <= S_LOAD;
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_netlist_net_collector.sv
// Directed bench for netlist_net_collector: a 16-net instance and a 15-net
// instance share stimulus; tsel routes the input stream and observed outputs.
module tb_netlist_net_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tsel = 1'b0;
   logic       c_valid = 1'b0;
   logic       c_last = 1'b0;
   logic [7:0] c_inst = '0;
   logic [2:0] c_pin = '0;
   logic [3:0] c_net = '0;
   logic       out_ready = 1'b1;

   logic       a_in_ready, a_out_valid, a_out_first, a_done, a_err_ovf, a_err_rng;
   logic [7:0] a_out_inst;
   logic [2:0] a_out_pin;
   logic [3:0] a_out_net;
   logic       b_in_ready, b_out_valid, b_out_first, b_done, b_err_ovf, b_err_rng;
   logic [7:0] b_out_inst;
   logic [2:0] b_out_pin;
   logic [3:0] b_out_net;

   logic       m_in_ready, m_out_valid, m_out_first, m_done, m_err_ovf, m_err_rng;
   logic [7:0] m_out_inst;
   logic [2:0] m_out_pin;
   logic [3:0] m_out_net;

   int n_chk = 0;
   int n_fail = 0;

   logic [14:0] ld[$];
   logic [15:0] exp_q[$];
   logic [15:0] got[$];
   int done_cnt, done_cyc, first_cyc;

   always #5 clk = ~clk;

   netlist_net_collector #(.NUM_NETS(16)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(c_valid & ~tsel), .in_ready(a_in_ready),
      .in_inst(c_inst), .in_pin(c_pin), .in_net(c_net), .in_last(c_last),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_inst(a_out_inst), .out_pin(a_out_pin), .out_net(a_out_net),
      .out_first(a_out_first), .done(a_done),
      .err_overflow(a_err_ovf), .err_range(a_err_rng)
   );

   netlist_net_collector #(.NUM_NETS(15)) u_dut15 (
      .clk(clk), .rst(rst),
      .in_valid(c_valid & tsel), .in_ready(b_in_ready),
      .in_inst(c_inst), .in_pin(c_pin), .in_net(c_net), .in_last(c_last),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_inst(b_out_inst), .out_pin(b_out_pin), .out_net(b_out_net),
      .out_first(b_out_first), .done(b_done),
      .err_overflow(b_err_ovf), .err_range(b_err_rng)
   );

   assign m_in_ready  = tsel ? b_in_ready  : a_in_ready;
   assign m_out_valid = tsel ? b_out_valid : a_out_valid;
   assign m_out_first = tsel ? b_out_first : a_out_first;
   assign m_out_inst  = tsel ? b_out_inst  : a_out_inst;
   assign m_out_pin   = tsel ? b_out_pin   : a_out_pin;
   assign m_out_net   = tsel ? b_out_net   : a_out_net;
   assign m_done      = tsel ? b_done      : a_done;
   assign m_err_ovf   = tsel ? b_err_ovf   : a_err_ovf;
   assign m_err_rng   = tsel ? b_err_rng   : a_err_rng;

   function automatic logic [14:0] R(input int i, input int p, input int n);
      return {8'(i), 3'(p), 4'(n)};
   endfunction

   function automatic logic [15:0] E(input int i, input int p, input int n, input int f);
      return {R(i, p, n), 1'(f)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_basic();
      ld.delete();
      exp_q.delete();
      ld.push_back(R(1,0,0)); ld.push_back(R(1,1,3)); ld.push_back(R(2,0,2));
      ld.push_back(R(2,1,5)); ld.push_back(R(3,0,2)); ld.push_back(R(3,1,3));
`ifdef NETCOL_DANGLING_DROP_EN
      exp_q.push_back(E(2,0,2,1)); exp_q.push_back(E(3,0,2,0));
      exp_q.push_back(E(1,1,3,1)); exp_q.push_back(E(3,1,3,0));
`else
      exp_q.push_back(E(1,0,0,1)); exp_q.push_back(E(2,0,2,1)); exp_q.push_back(E(3,0,2,0));
      exp_q.push_back(E(1,1,3,1)); exp_q.push_back(E(3,1,3,0)); exp_q.push_back(E(2,1,5,1));
`endif
   endtask

   // Drives every record of ld; in_last on the final one.
   task automatic load_recs();
      for (int i = 0; i < ld.size(); i++) begin
         int w = 0;
         while (!m_in_ready && w < 300) begin tick(); w++; end
         n_chk++;
         if (m_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready rec %0d: in_ready=%b required 1", i, m_in_ready);
         end
         c_valid = 1'b1;
         {c_inst, c_pin, c_net} = ld[i];
         c_last = (i == ld.size() - 1);
         tick();
      end
      c_valid = 1'b0;
      c_last  = 1'b0;
   endtask

   // Collects emits until done plus a few cycles; cycle 0 is just after the in_last edge.
   task automatic run_scan(input bit toggle, input int budget);
      logic [15:0] prev = '0;
      bit prev_stall = 1'b0;
      int after = 0;
      got.delete();
      done_cnt = 0; done_cyc = -1; first_cyc = -1;
      for (int cyc = 0; cyc < budget && after < 4; cyc++) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (prev_stall) begin
            n_chk++;
            if ({m_out_valid, m_out_inst, m_out_pin, m_out_net, m_out_first} !== {1'b1, prev}) begin
               n_fail++;
               $display("FAIL stall_hold cyc %0d: got v=%b %h required v=1 %h", cyc, m_out_valid,
                        {m_out_inst, m_out_pin, m_out_net, m_out_first}, prev);
            end
         end
         if (m_out_valid && first_cyc < 0) first_cyc = cyc;
         if (m_out_valid && out_ready) got.push_back({m_out_inst, m_out_pin, m_out_net, m_out_first});
         prev_stall = m_out_valid && !out_ready;
         prev = {m_out_inst, m_out_pin, m_out_net, m_out_first};
         if (m_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
         if (done_cyc >= 0) after++;
         tick();
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_chk++;
      if ({a_in_ready, a_out_valid, a_out_first, a_done, a_err_ovf, a_err_rng} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 100000",
                  {a_in_ready, a_out_valid, a_out_first, a_done, a_err_ovf, a_err_rng});
      end
      n_chk++;
      if ({a_out_inst, a_out_pin, a_out_net} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {a_out_inst, a_out_pin, a_out_net});
      end
      n_chk++;
      if ({b_in_ready, b_out_valid, b_done} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_dut15: got %b required 100", {b_in_ready, b_out_valid, b_done});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic(input bit toggle, input string nm);
      set_basic();
      load_recs();
      run_scan(toggle, 600);
      n_chk++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL %s_done_pulses: got %0d required 1", nm, done_cnt);
      end
      n_chk++;
      if (!toggle && (done_cyc < 96 || done_cyc > 196)) begin
         n_fail++; $display("FAIL %s_done_time: got %0d required 96..196", nm, done_cyc);
      end
      n_chk++;
      if (first_cyc < 2) begin
         n_fail++; $display("FAIL %s_first_latency: got %0d required >=2", nm, first_cyc);
      end
      n_chk++;
      if (got.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s_count: got %0d required %0d", nm, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL %s_emit[%0d]: got %h required %h", nm, i, got[i], exp_q[i]);
         end
      end
      n_chk++;
      if (m_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s_ready_after: got %b required 1", nm, m_in_ready);
      end
   endtask

   task automatic test_overflow();
      ld.delete();
      for (int i = 0; i < 65; i++) ld.push_back(R(i, 0, 1));
      load_recs();
      n_chk++;
      if ({m_err_ovf, m_err_rng} !== 2'b10) begin
         n_fail++; $display("FAIL ovf_flags: got %b required 10", {m_err_ovf, m_err_rng});
      end
      run_scan(1'b0, 5000);
      n_chk++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL ovf_done_pulses: got %0d required 1", done_cnt);
      end
      n_chk++;
      if (got.size() != 64) begin
         n_fail++; $display("FAIL ovf_count: got %0d required 64", got.size());
      end
      for (int i = 0; i < 64 && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== E(i, 0, 1, (i == 0))) begin
            n_fail++; $display("FAIL ovf_emit[%0d]: got %h required %h", i, got[i], E(i, 0, 1, (i == 0)));
         end
      end
      n_chk++;
      if (m_err_ovf !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sticky: got %b required 1", m_err_ovf);
      end
   endtask

   task automatic test_back_to_back();
      test_basic(1'b0, "b2b");
      n_chk++;
      if (m_err_ovf !== 1'b0) begin
         n_fail++; $display("FAIL b2b_ovf_cleared: got %b required 0", m_err_ovf);
      end
   endtask

   task automatic test_range();
      tsel = 1'b1;
      ld.delete();
      ld.push_back(R(4,2,15)); ld.push_back(R(5,1,3)); ld.push_back(R(6,0,3));
      load_recs();
      n_chk++;
      if ({m_err_rng, m_err_ovf} !== 2'b10) begin
         n_fail++; $display("FAIL range_flags: got %b required 10", {m_err_rng, m_err_ovf});
      end
      run_scan(1'b0, 400);
      n_chk++;
      if (got.size() != 2 || done_cnt != 1) begin
         n_fail++; $display("FAIL range_count: got %0d emits %0d done required 2 emits 1 done", got.size(), done_cnt);
      end
      n_chk++;
      if (got.size() == 2 && {got[0], got[1]} !== {E(5,1,3,1), E(6,0,3,0)}) begin
         n_fail++; $display("FAIL range_emits: got %h %h required %h %h", got[0], got[1], E(5,1,3,1), E(6,0,3,0));
      end
      ld.delete();
      ld.push_back(R(7,0,15));
      load_recs();
      run_scan(1'b0, 100);
      n_chk++;
      if (got.size() != 0 || done_cnt != 1 || m_err_rng !== 1'b1) begin
         n_fail++; $display("FAIL range_only_bad: got %0d emits %0d done err=%b required 0 1 1", got.size(), done_cnt, m_err_rng);
      end
      tsel = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      int k = 0;
      int em = 0;
      set_basic();
      load_recs();
      out_ready = 1'b1;
      while (em < 2 && k < 300) begin
         if (m_out_valid) em++;
         tick();
         k++;
      end
      n_chk++;
      if (em != 2) begin
         n_fail++; $display("FAIL midrst_wait: got %0d emits required 2", em);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if ({a_out_valid, a_in_ready, a_done} !== 3'b010) begin
         n_fail++; $display("FAIL midrst_state: got %b required 010", {a_out_valid, a_in_ready, a_done});
      end
      tick();
      rst = 1'b0;
      tick();
      test_basic(1'b0, "reload");
   endtask

   initial begin
      test_reset();
      test_basic(1'b0, "basic");
      test_basic(1'b1, "stall");
      test_overflow();
      test_back_to_back();
      test_range();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
